// File: rtl/md_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl_if
// Description : Request/response bundle between md_ctrl and the shared
//               multiply/divide core (operands, op class, valid/ready pairs,
//               LO/HI results).
// Revision    : 1.0 - initial release
// ============================================================================
interface md_ctrl_if;
  logic [31:0] core_src0;
  logic [31:0] core_src1;
  logic [1:0]  core_op;
  logic        core_sign;
  logic        core_in_valid;
  logic        core_in_ready;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [31:0] core_res0;
  logic [31:0] core_res1;

  // Controller side
  modport master (
    output core_src0, core_src1, core_op, core_sign, core_in_valid, core_out_ready,
    input  core_in_ready, core_out_valid, core_res0, core_res1
  );

  // Core side
  modport slave (
    input  core_src0, core_src1, core_op, core_sign, core_in_valid, core_out_ready,
    output core_in_ready, core_out_valid, core_res0, core_res1
  );
endinterface
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : E-stage multiply/divide controller. Issues mult/div ops to the
//               shared core, enforces a minimum busy window per op class,
//               owns HI/LO and raises the stall used to hold later md ops.
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_flush,
  output logic        md_busy,
  output logic        md_stall,
  output logic [31:0] md_rdata,
  md_ctrl_if.master   core
);

  localparam logic [3:0] c_op_mult  = 4'd1;
  localparam logic [3:0] c_op_multu = 4'd2;
  localparam logic [3:0] c_op_div   = 4'd3;
  localparam logic [3:0] c_op_divu  = 4'd4;
  localparam logic [3:0] c_op_mfhi  = 4'd5;
  localparam logic [3:0] c_op_mflo  = 4'd6;
  localparam logic [3:0] c_op_mthi  = 4'd7;
  localparam logic [3:0] c_op_mtlo  = 4'd8;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  localparam logic [7:0] c_mul_cnt = 8'(MUL_CYCLES);
  localparam logic [7:0] c_div_cnt = 8'(DIV_CYCLES);

  logic [0:0]  r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [7:0]  r_cnt;
  logic        r_got;

  logic w_is_mul;
  logic w_is_div;
  logic w_op_valid;
  logic w_busy;
  logic w_in_valid;
  logic w_issue;
  logic w_done;
  logic w_stall;
  logic w_mt_en;

  // Op decode, issue qualification and exit condition
  always_comb begin
    w_is_mul   = (md_op == c_op_mult) || (md_op == c_op_multu);
    w_is_div   = (md_op == c_op_div)  || (md_op == c_op_divu);
    // Codes above MTLO behave as NONE, so they never stall
    w_op_valid = (md_op != 4'd0) && (md_op <= c_op_mtlo);
    w_busy     = (r_state == c_st_busy);
    w_in_valid = !w_busy && (w_is_mul || w_is_div) && !md_flush;
    w_issue    = w_in_valid && core.core_in_ready;
    // Leave once a result has arrived (now or earlier) and the minimum window expires
    w_done     = (r_got || core.core_out_valid) && (r_cnt <= 8'd1);
    w_stall    = w_busy && w_op_valid;
    w_mt_en    = !w_stall && !md_flush;
  end

  assign core.core_src0      = md_a;
  assign core.core_src1      = md_b;
  assign core.core_op        = w_is_mul ? 2'b01 : (w_is_div ? 2'b10 : 2'b00);
  assign core.core_sign      = (md_op == c_op_mult) || (md_op == c_op_div);
  assign core.core_in_valid  = w_in_valid;
  assign core.core_out_ready = w_busy;

  assign md_busy  = w_busy;
  assign md_stall = w_stall;

  // HI/LO read mux; only meaningful while not stalled
  always_comb begin
    md_rdata = 32'd0;
    if (md_op == c_op_mfhi) begin
      md_rdata = r_hi;
    end else if (md_op == c_op_mflo) begin
      md_rdata = r_lo;
    end
  end

  // Busy-window sequencer: minimum-cycle counter plus result-seen flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
      r_cnt   <= 8'd0;
      r_got   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_issue) begin
            r_state <= c_st_busy;
            r_got   <= 1'b0;
            r_cnt   <= w_is_mul ? c_mul_cnt : c_div_cnt;
          end
        end
        c_st_busy: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end
          if (core.core_out_valid) begin
            r_got <= 1'b1;
          end
          if (w_done) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // HI/LO: core results land only while busy; MT writes only when not stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_busy && core.core_out_valid) begin
      r_lo <= core.core_res0;
      r_hi <= core.core_res1;
    end else begin
      if ((md_op == c_op_mthi) && w_mt_en) begin
        r_hi <= md_a;
      end
      if ((md_op == c_op_mtlo) && w_mt_en) begin
        r_lo <= md_a;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_ctrl
// Description : Self-checking bench for md_ctrl. The bench plays the md core
//               (random latency, arithmetic results) and predicts every output
//               from busy windows and HI/LO contents kept as plain variables.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (MUL_CYCLES=5, DIV_CYCLES=10)
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_flush;
  logic        md_busy, md_stall;
  logic [31:0] md_rdata;
  md_ctrl_if   cif ();

  md_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_flush (md_flush),
    .md_busy  (md_busy),
    .md_stall (md_stall),
    .md_rdata (md_rdata),
    .core     (cif)
  );

  // Second build with no multiply minimum
  logic        reset0;
  logic [3:0]  md_op0;
  logic [31:0] md_a0, md_b0;
  logic        md_flush0;
  logic        md_busy0, md_stall0;
  logic [31:0] md_rdata0;
  md_ctrl_if   cif0 ();

  md_ctrl #(.MUL_CYCLES(0), .DIV_CYCLES(10)) u_dut0 (
    .clk      (clk),
    .reset    (reset0),
    .md_op    (md_op0),
    .md_a     (md_a0),
    .md_b     (md_b0),
    .md_flush (md_flush0),
    .md_busy  (md_busy0),
    .md_stall (md_stall0),
    .md_rdata (md_rdata0),
    .core     (cif0)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference state
  int          cyc        = 0;
  int          busy_first = -1;
  int          busy_last  = -2;
  int          pend_at    = -1;
  logic [31:0] pend_lo, pend_hi;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          next_lat   = 1;

  // Observations for literal checks
  int          run = 0;
  int          last_run = 0;
  logic [31:0] last_rdata;
  logic        last_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = 64'd0;
    case (op)
      4'd1: res = 64'(sa * sb);
      4'd2: res = ua * ub;
      4'd3: begin
        sq = sa / sb;
        sr = sa % sb;
        res = {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // One clock cycle: drive, compare every output against the reference, advance the reference
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic fl, input logic rs);
    logic        e_busy, e_opv, e_stall, e_inv, e_sign;
    logic [31:0] e_rdata;
    logic [1:0]  e_cop;
    logic [63:0] r;
    int          n;
    @(negedge clk);
    md_op    = op;
    md_a     = a;
    md_b     = b;
    md_flush = fl;
    reset    = rs;
    cif.core_in_ready  = 1'b1;
    cif.core_out_valid = (cyc == pend_at);
    cif.core_res0      = (cyc == pend_at) ? pend_lo : $urandom;
    cif.core_res1      = (cyc == pend_at) ? pend_hi : $urandom;
    #1;
    e_busy  = (cyc >= busy_first) && (cyc <= busy_last);
    e_opv   = (op >= 4'd1) && (op <= 4'd8);
    e_stall = e_busy && e_opv;
    e_inv   = !e_busy && (op >= 4'd1) && (op <= 4'd4) && !fl;
    e_rdata = (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'd0);
    e_cop   = (op == 4'd1 || op == 4'd2) ? 2'b01 : ((op == 4'd3 || op == 4'd4) ? 2'b10 : 2'b00);
    e_sign  = (op == 4'd1) || (op == 4'd3);
    chk("md_busy",        {31'd0, md_busy},            {31'd0, e_busy});
    chk("md_stall",       {31'd0, md_stall},           {31'd0, e_stall});
    chk("core_in_valid",  {31'd0, cif.core_in_valid},  {31'd0, e_inv});
    chk("core_out_ready", {31'd0, cif.core_out_ready}, {31'd0, e_busy});
    chk("md_rdata",       md_rdata,                    e_rdata);
    chk("core_op",        {30'd0, cif.core_op},        {30'd0, e_cop});
    chk("core_sign",      {31'd0, cif.core_sign},      {31'd0, e_sign});
    chk("core_src0",      cif.core_src0,               a);
    chk("core_src1",      cif.core_src1,               b);
    last_rdata = md_rdata;
    last_stall = md_stall;
    if (md_busy === 1'b1) begin
      run++;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    @(posedge clk);
    if (rs) begin
      busy_first = -1;
      busy_last  = -2;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      if (cif.core_out_valid && e_busy) begin
        m_lo = pend_lo;
        m_hi = pend_hi;
      end
      if (op == 4'd7 && !e_stall && !fl) m_hi = a;
      if (op == 4'd8 && !e_stall && !fl) m_lo = a;
      if (e_inv) begin
        r       = calc(op, a, b);
        pend_lo = r[31:0];
        pend_hi = r[63:32];
        pend_at = cyc + next_lat;
        n       = (op <= 4'd2) ? 5 : 10;
        busy_first = cyc + 1;
        busy_last  = cyc + ((n > next_lat) ? n : next_lat);
      end
    end
    cyc++;
  endtask

  // Idle until the reference has no busy window and no outstanding core response
  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (cyc > busy_last && cyc > pend_at) break;
      step(4'd0, $urandom, $urandom, 1'b0, 1'b0);
    end
  endtask

  logic [3:0]  rop;
  logic [31:0] ra, rb;
  logic        rfl, rrs;
  int          nstall;

  initial begin
    reset = 1'b1; md_op = 4'd0; md_a = 32'd0; md_b = 32'd0; md_flush = 1'b0;
    cif.core_in_ready = 1'b1; cif.core_out_valid = 1'b0;
    cif.core_res0 = 32'd0; cif.core_res1 = 32'd0;
    reset0 = 1'b1; md_op0 = 4'd0; md_a0 = 32'd0; md_b0 = 32'd0; md_flush0 = 1'b0;
    cif0.core_in_ready = 1'b1; cif0.core_out_valid = 1'b0;
    cif0.core_res0 = 32'd0; cif0.core_res1 = 32'd0;
    @(posedge clk);

    // Reset state, including reads of the cleared registers
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset_lo_read", last_rdata, 32'd0);

    // Signed MULT -1 * 2
    next_lat = 1;
    step(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    drain();
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mult_busy_len", last_run, 32'd5);
    chk("mult_hi", last_rdata, 32'hFFFFFFFF);
    chk("mult_model_lo", m_lo, 32'hFFFFFFFE);

    // DIVU 7/2 with a slow core, then DIV -7/2 with a fast core
    next_lat = 12;
    step(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    drain();
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("divu_busy_len", last_run, 32'd12);
    chk("divu_lo", last_rdata, 32'd3);
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("divu_hi", last_rdata, 32'd1);
    next_lat = 3;
    step(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    drain();
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("div_busy_len", last_run, 32'd10);
    chk("div_lo", last_rdata, 32'hFFFFFFFD);
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("div_hi", last_rdata, 32'hFFFFFFFF);

    // MULTU 3*4 followed at once by a stalled MFLO
    next_lat = 1;
    step(4'd2, 32'd3, 32'd4, 1'b0, 1'b0);
    nstall = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
      if (last_stall !== 1'b1) break;
      nstall++;
    end
    chk("mflo_stall_cycles", nstall, 32'd5);
    chk("mflo_after_stall", last_rdata, 32'd12);

    // Flushed MULT does nothing; flushed MTHI does nothing; plain MTHI writes
    step(4'd1, 32'd5, 32'd6, 1'b1, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_lo_kept", last_rdata, 32'd12);
    step(4'd7, 32'h1234, 32'd0, 1'b1, 1'b0);
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_mthi_hi", last_rdata, 32'd0);
    step(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mthi_hi", last_rdata, 32'h1234);
    step(4'd8, 32'h55AA, 32'd0, 1'b0, 1'b0);
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("mtlo_lo", last_rdata, 32'h55AA);

    // Reset three cycles into a DIV; the late core response arrives while idle
    next_lat = 12;
    step(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    drain();
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_hi", last_rdata, 32'd0);
    next_lat = 1;
    step(4'd2, 32'd5, 32'd5, 1'b0, 1'b0);
    drain();
    step(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("multu_after_rst_lo", last_rdata, 32'd25);
    step(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("multu_after_rst_hi", last_rdata, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rop = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 4)) : 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom;
      if ((rop == 4'd3 || rop == 4'd4) && rb == 32'd0) rb = 32'd1;
      rfl = ($urandom_range(0, 7) == 0);
      rrs = ($urandom_range(0, 299) == 0);
      // A stale response from a reset op must not overlap a new issue
      if (cyc > busy_last && pend_at >= cyc && rop >= 4'd1 && rop <= 4'd4) rop = 4'd0;
      next_lat = (rop <= 4'd2) ? $urandom_range(1, 3) : $urandom_range(1, 16);
      step(rop, ra, rb, rfl, rrs);
    end
    drain();

    // MUL_CYCLES=0 build: MULT 2*3 busy for exactly one cycle
    @(negedge clk);
    reset0 = 1'b0; md_op0 = 4'd1; md_a0 = 32'd2; md_b0 = 32'd3;
    #1;
    chk("m0_issue", {31'd0, cif0.core_in_valid}, 32'd1);
    chk("m0_idle_before", {31'd0, md_busy0}, 32'd0);
    @(negedge clk);
    md_op0 = 4'd0; cif0.core_out_valid = 1'b1; cif0.core_res0 = 32'd6; cif0.core_res1 = 32'd0;
    #1;
    chk("m0_busy_1", {31'd0, md_busy0}, 32'd1);
    @(negedge clk);
    cif0.core_out_valid = 1'b0; cif0.core_res0 = 32'hDEAD; md_op0 = 4'd6;
    #1;
    chk("m0_busy_done", {31'd0, md_busy0}, 32'd0);
    chk("m0_lo", md_rdata0, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
# md_ctrl

Execute-stage controller that sequences the shared multiply/divide core (`MDCore`) for the pipeline and owns the architectural HI/LO registers. It turns E-stage `mult/multu/div/divu/mfhi/mflo/mthi/mtlo` operations into valid/ready transactions on the core. It enforces a minimum busy window per operation class and produces the stall the hazard unit uses to hold later multiply/divide instructions.

## Interface
Parameters:
- MUL_CYCLES, 5, minimum busy cycles after a multiply issue (0..255; 0 means no minimum)
- DIV_CYCLES, 10, minimum busy cycles after a divide issue (0..255; 0 means no minimum)

Ports:
- clk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high; the same signal also resets `MDCore`
- md_op  in  4  E-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; codes 9..15 are treated as NONE
- md_a  in  32  rs operand (dividend / multiplicand / MT data)
- md_b  in  32  rt operand (divisor / multiplier)
- md_flush  in  1  E-stage instruction is being killed this cycle
- md_busy  out  1  a core operation is outstanding (registered)
- md_stall  out  1  hold E: md_busy & (md_op != NONE)
- md_rdata  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- core_src0 / core_src1  out  32  md_a / md_b, combinational pass-through
- core_op  out  2  01 for MULT/MULTU, 10 for DIV/DIVU, else 00
- core_sign  out  1  1 for MULT/DIV, else 0
- core_in_valid  out  1  issue request
- core_in_ready  in  1
- core_out_valid  in  1
- core_out_ready  out  1
- core_res0 / core_res1  in  32  LO/quotient, HI/remainder

## Operation
- Two states.
  - IDLE: md_busy=0, core_out_ready=0.
  - BUSY: md_busy=1, core_out_ready=1.
- Registers: HI, LO (32 bits each), cnt (8 bits), got (1 bit).
- Issue: core_in_valid = IDLE & op∈{1..4} & !md_flush.
  - On an edge with core_in_valid & core_in_ready: go to BUSY, got<=0, cnt<=MUL_CYCLES or DIV_CYCLES.
  - If core_in_ready=0 in IDLE: no issue and no stall (md_busy=0); the op is lost. Hazard logic guarantees this cannot occur; the bench flags it as an error.
- BUSY, every edge:
  - If cnt≠0: cnt<=cnt-1.
  - If core_out_valid: LO<=core_res0, HI<=core_res1, got<=1.
  - Exit to IDLE at the edge where (got | core_out_valid) & cnt≤1.
- Resulting busy length: max(N, L) cycles. N is the loaded minimum; L≥1 is the number of cycles from issue to the first core_out_valid, inclusive.
- MTHI/MTLO: HI<=md_a or LO<=md_a at the edge when !md_stall & !md_flush.
- MFHI/MFLO: md_rdata reads current HI/LO. The value is valid only when md_stall=0; while busy, the read is stalled until HI/LO hold the new result.
- md_op NONE/invalid: no effect. md_flush: suppresses issue and MT writes only. md_stall is not gated by md_flush; flush has priority in the hazard unit.
- The result of an issued op is never cancelled; it always completes into HI/LO.

## Timing
- Reset values: state IDLE, HI=LO=0, cnt=0, got=0. Outputs: md_busy=0, md_stall=0, core_in_valid=0, core_out_ready=0, md_rdata=0 unless md_op is MFHI/MFLO (then 0 from the cleared registers).
- Issue at edge t (the instruction itself does not stall). md_busy is high for cycles t+1 .. t+max(N, L).
- With the current core (multiply L=1), MULT busy is exactly MUL_CYCLES cycles. Divide busy is max(DIV_CYCLES, core latency).
- HI/LO update at the edge that ends the core_out_valid cycle. core_out_ready=1 during BUSY guarantees a single-cycle result handshake.
- The next md op may issue in the first cycle after md_busy falls; back-to-back issues therefore have a gap of max(N, L) cycles.
- Reset mid-operation: returns to IDLE next edge, HI/LO cleared. Any later core_out_valid while IDLE is ignored (the core is reset by the same signal).

## Test plan
- MULT a=0xFFFFFFFF, b=2 (signed) -> issue handshake, md_busy high exactly 5 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- DIVU 7/2, then DIV 0xFFFFFFF9/2 -> first LO=3, HI=1; second LO=0xFFFFFFFD, HI=0xFFFFFFFF; each busy ≥10 cycles, no overlap.
- MULTU 3*4 followed immediately by MFLO -> md_stall high every busy cycle; MFLO completes on the first non-busy cycle with md_rdata=12.
- MULT with md_flush=1 in the issue cycle -> no core_in_valid, md_busy stays 0, HI/LO unchanged. MTHI 0x1234 with flush=1 -> HI unchanged; without flush, MFHI then returns 0x1234.
- Reset asserted 3 cycles into a DIV -> next cycle md_busy=0, HI=LO=0. A fresh MULTU 5*5 then yields LO=25, HI=0.
- MUL_CYCLES=0 build, MULT 2*3 -> md_busy high exactly 1 cycle, LO=6.
